alu_cmd_driver: RTL and testbench

//  Command-side initiator for the combinational 32-bit ALU. Accepts one operation request
//  (opcode, A, B) per valid/ready handshake, drives the ALU operand/function inputs, waits a

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_ref_model.sv | 31 +++
 rtl/alu_cmd_driver.sv | 161 ++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU command driver: default data width, ALU function codes
// and the driver FSM state encoding.
package alu_pkg;

   localparam int unsigned BW_DATA_DFLT = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_RSVD = 3'b011;
   localparam logic [2:0] OP_ANDN = 3'b100;
   localparam logic [2:0] OP_ORN  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDrive = 2'd1,
      StResp  = 2'd2
   } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU function of op/A/B, used by the driver to flag responses
// that disagree with the attached ALU.
module alu_ref_model
   import alu_pkg::*;
#(
   parameter int unsigned BW_DATA = BW_DATA_DFLT
) (
   input  logic [2:0]         i_op,
   input  logic [BW_DATA-1:0] i_a,
   input  logic [BW_DATA-1:0] i_b,
   output logic [BW_DATA-1:0] o_y
);

   logic slt;

   always_comb begin
      slt = ($signed(i_a) < $signed(i_b));
      o_y = '0;
      case (i_op)
         OP_AND:  o_y = i_a & i_b;
         OP_OR:   o_y = i_a | i_b;
         OP_ADD:  o_y = i_a + i_b;
         OP_ANDN: o_y = i_a & ~i_b;
         OP_ORN:  o_y = i_a | ~i_b;
         OP_SUB:  o_y = i_a - i_b;
         OP_SLT:  o_y = BW_DATA'(slt);
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// Valid/ready command initiator for the combinational ALU: drives operands, waits a fixed
// settle time, captures the result. Define ALU_CMD_DRIVER_CHECK_EN to add o_rsp_mismatch.
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int unsigned BW_DATA       = BW_DATA_DFLT,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned BW_CNT        = 16
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_cmd_valid,
   output logic               o_cmd_ready,
   input  logic [2:0]         i_cmd_op,
   input  logic [BW_DATA-1:0] i_cmd_a,
   input  logic [BW_DATA-1:0] i_cmd_b,
   output logic [BW_DATA-1:0] o_alu_a,
   output logic [BW_DATA-1:0] o_alu_b,
   output logic [2:0]         o_alu_f,
   input  logic [BW_DATA-1:0] i_alu_y,
   output logic               o_rsp_valid,
   input  logic               i_rsp_ready,
   output logic [BW_DATA-1:0] o_rsp_y,
   output logic               o_rsp_zero,
   output logic               o_rsp_err,
   output logic [BW_CNT-1:0]  o_op_cnt
`ifdef ALU_CMD_DRIVER_CHECK_EN
   ,
   output logic               o_rsp_mismatch
`endif
);

   localparam int unsigned BW_SET = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [BW_SET-1:0] SETTLE_LAST = BW_SET'(SETTLE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [BW_SET-1:0]   set_cnt_q, set_cnt_d;
   logic [BW_DATA-1:0]  alu_a_q, alu_a_d;
   logic [BW_DATA-1:0]  alu_b_q, alu_b_d;
   logic [2:0]          alu_f_q, alu_f_d;
   logic [BW_DATA-1:0]  rsp_y_q, rsp_y_d;
   logic                rsp_zero_q, rsp_zero_d;
   logic                rsp_err_q, rsp_err_d;
   logic [BW_CNT-1:0]   op_cnt_q, op_cnt_d;

`ifdef ALU_CMD_DRIVER_CHECK_EN
   logic                mismatch_q, mismatch_d;
   logic [BW_DATA-1:0]  ref_y;

   // Model sees the registered operands, i.e. exactly what the ALU is being driven with.
   alu_ref_model #(
      .BW_DATA (BW_DATA)
   ) u_ref (
      .i_op (alu_f_q),
      .i_a  (alu_a_q),
      .i_b  (alu_b_q),
      .o_y  (ref_y)
   );
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         set_cnt_q  <= '0;
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_f_q    <= '0;
         rsp_y_q    <= '0;
         rsp_zero_q <= 1'b0;
         rsp_err_q  <= 1'b0;
         op_cnt_q   <= '0;
`ifdef ALU_CMD_DRIVER_CHECK_EN
         mismatch_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         set_cnt_q  <= set_cnt_d;
         alu_a_q    <= alu_a_d;
         alu_b_q    <= alu_b_d;
         alu_f_q    <= alu_f_d;
         rsp_y_q    <= rsp_y_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_err_q  <= rsp_err_d;
         op_cnt_q   <= op_cnt_d;
`ifdef ALU_CMD_DRIVER_CHECK_EN
         mismatch_q <= mismatch_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      set_cnt_d  = set_cnt_q;
      alu_a_d    = alu_a_q;
      alu_b_d    = alu_b_q;
      alu_f_d    = alu_f_q;
      rsp_y_d    = rsp_y_q;
      rsp_zero_d = rsp_zero_q;
      rsp_err_d  = rsp_err_q;
      op_cnt_d   = op_cnt_q;
`ifdef ALU_CMD_DRIVER_CHECK_EN
      mismatch_d = mismatch_q;
`endif
      case (state_q)
         StIdle: begin
            if (i_cmd_valid) begin
               if (i_cmd_op == OP_RSVD) begin
                  // Reserved op never reaches the ALU; operands keep their last values.
                  rsp_y_d    = '0;
                  rsp_zero_d = 1'b1;
                  rsp_err_d  = 1'b1;
`ifdef ALU_CMD_DRIVER_CHECK_EN
                  mismatch_d = 1'b0;
`endif
                  state_d    = StResp;
               end else begin
                  alu_a_d   = i_cmd_a;
                  alu_b_d   = i_cmd_b;
                  alu_f_d   = i_cmd_op;
                  set_cnt_d = '0;
                  state_d   = StDrive;
               end
            end
         end
         StDrive: begin
            if (set_cnt_q == SETTLE_LAST) begin
               rsp_y_d    = i_alu_y;
               rsp_zero_d = (i_alu_y == '0);
               rsp_err_d  = 1'b0;
`ifdef ALU_CMD_DRIVER_CHECK_EN
               mismatch_d = (i_alu_y != ref_y);
`endif
               state_d    = StResp;
            end else begin
               set_cnt_d = set_cnt_q + 1'b1;
            end
         end
         StResp: begin
            if (i_rsp_ready) begin
               op_cnt_d = op_cnt_q + 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign o_cmd_ready = (state_q == StIdle);
   assign o_rsp_valid = (state_q == StResp);
   assign o_alu_a     = alu_a_q;
   assign o_alu_b     = alu_b_q;
   assign o_alu_f     = alu_f_q;
   assign o_rsp_y     = rsp_y_q;
   assign o_rsp_zero  = rsp_zero_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_op_cnt    = op_cnt_q;
`ifdef ALU_CMD_DRIVER_CHECK_EN
   assign o_rsp_mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver with a behavioural ALU attached; response
// expectations flow through a scoreboard queue.
module tb_alu_cmd_driver;
   import alu_pkg::*;

   localparam int unsigned BW  = 32;
   localparam int unsigned SET = 1;
   localparam int unsigned BWC = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready;
   logic [2:0]    cmd_op;
   logic [BW-1:0] cmd_a, cmd_b;
   logic [BW-1:0] alu_a, alu_b, alu_y;
   logic [2:0]    alu_f;
   logic          rsp_valid, rsp_ready;
   logic [BW-1:0] rsp_y;
   logic          rsp_zero, rsp_err;
   logic [BWC-1:0] op_cnt;
   logic          rsp_mismatch;
   logic          force_zero;

   always #5 clk = ~clk;

   function automatic logic [BW-1:0] alu_fn(input logic [2:0] f, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
      case (f)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b100:  return a & ~b;
         3'b101:  return a | ~b;
         3'b110:  return a - b;
         3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   assign alu_y = force_zero ? '0 : alu_fn(alu_f, alu_a, alu_b);

   alu_cmd_driver #(
      .BW_DATA       (BW),
      .SETTLE_CYCLES (SET),
      .BW_CNT        (BWC)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_cmd_valid    (cmd_valid),
      .o_cmd_ready    (cmd_ready),
      .i_cmd_op       (cmd_op),
      .i_cmd_a        (cmd_a),
      .i_cmd_b        (cmd_b),
      .o_alu_a        (alu_a),
      .o_alu_b        (alu_b),
      .o_alu_f        (alu_f),
      .i_alu_y        (alu_y),
      .o_rsp_valid    (rsp_valid),
      .i_rsp_ready    (rsp_ready),
      .o_rsp_y        (rsp_y),
      .o_rsp_zero     (rsp_zero),
      .o_rsp_err      (rsp_err),
      .o_op_cnt       (op_cnt)
`ifdef ALU_CMD_DRIVER_CHECK_EN
      ,
      .o_rsp_mismatch (rsp_mismatch)
`endif
   );

`ifndef ALU_CMD_DRIVER_CHECK_EN
   assign rsp_mismatch = 1'b0;
`endif

   typedef struct {
      logic [2:0]    op;
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      logic [BW-1:0] y;
      logic          zero;
      logic          err;
      logic          mm;
   } vec_t;

   typedef struct {
      logic [BW-1:0] y;
      logic          zero;
      logic          err;
      logic          mm;
      logic [2:0]    f;
   } exp_t;

   vec_t tbl [11];
   exp_t sb [$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cnt_model = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One full transaction; bp_cycles > 0 holds off the response consumer that long.
   task automatic run_cmd(input vec_t v, input int bp_cycles);
      exp_t          e;
      int            lat;
      logic          stable;
      logic [BW-1:0] y0, a0;
      @(negedge clk);
      check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
      e.y    = v.y;
      e.zero = v.zero;
      e.err  = v.err;
      e.mm   = v.mm;
      e.f    = (v.op == OP_RSVD) ? alu_f : v.op;
      cmd_valid = 1'b1;
      cmd_op    = v.op;
      cmd_a     = v.a;
      cmd_b     = v.b;
      @(posedge clk);
      sb.push_back(e);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      lat = 0;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!rsp_valid) begin
         n_chk++;
         n_fail++;
         $display("FAIL rsp_timeout: got no response, expected one within 20 cycles");
         void'(sb.pop_front());
         return;
      end
      // Reserved op reaches RESP on the accept edge itself.
      check("rsp_latency", 64'(lat), (v.op == OP_RSVD) ? 64'd0 : 64'(SET));
      e = sb.pop_front();
      check("rsp_y", 64'(rsp_y), 64'(e.y));
      check("rsp_zero", 64'(rsp_zero), 64'(e.zero));
      check("rsp_err", 64'(rsp_err), 64'(e.err));
      check("alu_f", 64'(alu_f), 64'(e.f));
`ifdef ALU_CMD_DRIVER_CHECK_EN
      check("rsp_mismatch", 64'(rsp_mismatch), 64'(e.mm));
`endif
      if (bp_cycles > 0) begin
         y0 = rsp_y;
         a0 = alu_a;
         stable = 1'b1;
         for (int i = 0; i < bp_cycles; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_ADD;
            cmd_a     = 32'h1234_0000 + i;
            cmd_b     = 32'h1;
            @(negedge clk);
            if (!rsp_valid || rsp_y !== y0 || cmd_ready || alu_a !== a0 ||
                rsp_err !== e.err)
               stable = 1'b0;
         end
         cmd_valid = 1'b0;
         check("backpressure_hold", 64'(stable), 64'd1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      cnt_model = (cnt_model + 1) % (1 << BWC);
      check("op_cnt", 64'(op_cnt), 64'(cnt_model));
      check("cmd_ready_after", 64'(cmd_ready), 64'd1);
      check("rsp_valid_after", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic seen;
      vec_t v;
      tbl[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{OP_SLT,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{OP_ANDN, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{OP_ORN,  32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{OP_SLT,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{OP_RSVD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b1, 1'b0};

      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_a = '0;
      cmd_b = '0;
      rsp_ready = 1'b0;
      force_zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset_op_cnt", 64'(op_cnt), 64'd0);
      check("reset_alu_a", 64'(alu_a), 64'd0);
      check("reset_alu_b", 64'(alu_b), 64'd0);
      check("reset_alu_f", 64'(alu_f), 64'd0);
      check("reset_rsp", {rsp_y, 29'd0, rsp_zero, rsp_err, rsp_mismatch}, 64'd0);

      for (int i = 0; i < 11; i++) run_cmd(tbl[i], 0);

      v = '{OP_ADD, 32'h0000_0007, 32'h0000_0008, 32'h0000_000F, 1'b0, 1'b0, 1'b0};
      run_cmd(v, 10);

      // Reset while the command is in DRIVE: it must vanish without a response.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op = OP_ADD;
      cmd_a = 32'd10;
      cmd_b = 32'd20;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("drive_cmd_ready", 64'(cmd_ready), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      cnt_model = 0;
      check("midreset_op_cnt", 64'(op_cnt), 64'd0);
      check("midreset_cmd_ready", 64'(cmd_ready), 64'd1);
      seen = 1'b0;
      rsp_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      check("midreset_no_rsp", 64'(seen), 64'd0);
      check("midreset_cnt_hold", 64'(op_cnt), 64'd0);

      // Enough completions to carry the 4-bit counter through 15 -> 0.
      for (int i = 0; i < 17; i++) run_cmd(tbl[i % 11], 0);

`ifdef ALU_CMD_DRIVER_CHECK_EN
      force_zero = 1'b1;
      v = '{OP_OR, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      run_cmd(v, 0);
      force_zero = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
